his_builder_pp: RTL and testbench



---
 rtl/his_builder_pp_if.sv | 23 ++
 rtl/his_builder_pp.sv | 199 +++++++++++++++++++
 tb/tb_his_builder_pp.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/his_builder_pp_if.sv
// Peak-record stream between the histogram builder and the depth/filter stage.
// Ports: pk_valid/pk_ready handshake; pk_pixel, pk_bin, pk_count payload.
interface his_builder_pp_if #(
  parameter int PIX_W   = 2,
  parameter int BIN_W   = 4,
  parameter int COUNT_W = 8
);
  logic               pk_valid;
  logic               pk_ready;
  logic [PIX_W-1:0]   pk_pixel;
  logic [BIN_W-1:0]   pk_bin;
  logic [COUNT_W-1:0] pk_count;

  modport master (
    output pk_valid, pk_pixel, pk_bin, pk_count,
    input  pk_ready
  );

  modport slave (
    input  pk_valid, pk_pixel, pk_bin, pk_count,
    output pk_ready
  );
endinterface

// File: rtl/his_builder_pp.sv
// Ping-pong per-pixel TDC histogram builder with on-the-fly peak tracking.
// Ports: clk, res (sync, active-high), in_valid/in_bin hits, pk (peak
// record stream, master), frame_done pulse, bank, sticky overrun.
// Option: define HIS_SAT_EN to saturate bin counts instead of wrapping.
module his_builder_pp #(
  parameter int BIN_W             = 4,
  parameter int COUNT_W           = 8,
  parameter int NUM_PIXELS        = 4,
  parameter int SAMPLES_PER_PIXEL = 2,
  parameter int ACQ_NUM           = 3
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  input  logic [BIN_W-1:0]  in_bin,
  his_builder_pp_if.master  pk,
  output logic              frame_done,
  output logic              bank,
  output logic              overrun
);

  localparam int NB = 1 << BIN_W;
  localparam int PIX_W =
    (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int SW =
    (SAMPLES_PER_PIXEL > 1) ? $clog2(SAMPLES_PER_PIXEL) : 1;
  localparam int AW =
    (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

  localparam logic [SW-1:0] S_LAST = SW'(SAMPLES_PER_PIXEL - 1);
  localparam logic [PIX_W-1:0] P_LAST = PIX_W'(NUM_PIXELS - 1);
  localparam logic [AW-1:0] A_LAST = AW'(ACQ_NUM - 1);
  localparam logic [COUNT_W-1:0] C_ONE = COUNT_W'(1);

  typedef enum logic {IDLE, SEND} st_t;

  logic [SW-1:0]      sample_cnt;
  logic [PIX_W-1:0]   pixel_cnt;
  logic [AW-1:0]      acq_cnt;
  logic               bank_q;
  logic               fd_q;
  logic               ovr_q;
  logic               pend;

  // Lazy clear: a bin's count is only meaningful while its flag is set.
  logic [NB-1:0]      vld [2][NUM_PIXELS];
  logic [COUNT_W-1:0] cnt_mem [2][NUM_PIXELS][NB];

  logic [COUNT_W-1:0] mx [NUM_PIXELS];
  logic [BIN_W-1:0]   mb [NUM_PIXELS];
  logic [COUNT_W-1:0] rc [NUM_PIXELS];
  logic [BIN_W-1:0]   rb [NUM_PIXELS];

  st_t                st, st_n;
  logic [PIX_W-1:0]   idx, idx_n;

  logic [COUNT_W-1:0] old_cnt;
  logic [COUNT_W-1:0] new_cnt;
  logic               peak_up;
  logic               s_wrap, p_wrap, a_wrap;
  logic               last;
  logic               busy;

  always_comb begin
    old_cnt = '0;
    if (vld[bank_q][pixel_cnt][in_bin])
      old_cnt = cnt_mem[bank_q][pixel_cnt][in_bin];
`ifdef HIS_SAT_EN
    new_cnt = (old_cnt == '1) ? old_cnt : old_cnt + C_ONE;
`else
    new_cnt = old_cnt + C_ONE;
`endif
    // A wrapped count is never above the held peak.
    peak_up = in_valid && (new_cnt > mx[pixel_cnt]);
    s_wrap  = (sample_cnt == S_LAST);
    p_wrap  = (pixel_cnt == P_LAST);
    a_wrap  = (acq_cnt == A_LAST);
    last    = in_valid && s_wrap && p_wrap && a_wrap;
    // The snapshot pending cycle counts as busy too.
    busy    = (st != IDLE) || pend;
  end

  always_ff @(posedge clk) begin
    if (in_valid && !res)
      cnt_mem[bank_q][pixel_cnt][in_bin] <= new_cnt;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sample_cnt <= '0;
      pixel_cnt  <= '0;
      acq_cnt    <= '0;
      bank_q     <= 1'b0;
      fd_q       <= 1'b0;
      ovr_q      <= 1'b0;
      pend       <= 1'b0;
      for (int p = 0; p < NUM_PIXELS; p++) begin
        vld[0][p] <= '0;
        vld[1][p] <= '0;
        mx[p]     <= '0;
        mb[p]     <= '0;
        rc[p]     <= '0;
        rb[p]     <= '0;
      end
    end else begin
      fd_q <= last;
      pend <= last && !busy;
      if (in_valid) begin
        vld[bank_q][pixel_cnt][in_bin] <= 1'b1;
        if (peak_up) begin
          mx[pixel_cnt] <= new_cnt;
          mb[pixel_cnt] <= in_bin;
        end
        if (!s_wrap) begin
          sample_cnt <= sample_cnt + 1'b1;
        end else begin
          sample_cnt <= '0;
          if (!p_wrap) begin
            pixel_cnt <= pixel_cnt + 1'b1;
          end else begin
            pixel_cnt <= '0;
            acq_cnt   <= a_wrap ? '0 : acq_cnt + 1'b1;
          end
        end
      end
      if (last) begin
        bank_q <= ~bank_q;
        for (int p = 0; p < NUM_PIXELS; p++) begin
          vld[~bank_q][p] <= '0;
          mx[p] <= '0;
          mb[p] <= '0;
          // Snapshot includes the frame's final hit.
          if (!busy) begin
            if (peak_up && pixel_cnt == PIX_W'(p)) begin
              rc[p] <= new_cnt;
              rb[p] <= in_bin;
            end else begin
              rc[p] <= mx[p];
              rb[p] <= mb[p];
            end
          end
        end
        if (busy)
          ovr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      st  <= IDLE;
      idx <= '0;
    end else begin
      st  <= st_n;
      idx <= idx_n;
    end
  end

  always_comb begin
    st_n  = st;
    idx_n = idx;
    unique case (st)
      IDLE: begin
        if (pend) begin
          st_n  = SEND;
          idx_n = '0;
        end
      end
      SEND: begin
        if (pk.pk_ready) begin
          if (idx == P_LAST) begin
            st_n  = IDLE;
            idx_n = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    pk.pk_valid = (st == SEND);
    pk.pk_pixel = '0;
    pk.pk_bin   = '0;
    pk.pk_count = '0;
    if (st == SEND) begin
      pk.pk_pixel = idx;
      pk.pk_bin   = rb[idx];
      pk.pk_count = rc[idx];
    end
  end

  assign frame_done = fd_q;
  assign bank       = bank_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_his_builder_pp.sv
// Bench for his_builder_pp: two instances (COUNT_W 8 and 2) checked against
// a hit-list reference model, plus literal checks of key scenarios.
module tb_his_builder_pp;

  localparam int S = 2;
  localparam int N = 4;
  localparam int A = 3;
  localparam int FH = S * N * A;

  logic clk = 1'b0;
  logic res;
  logic in_valid;
  logic [3:0] in_bin;
  logic ready;
  logic fd1, bk1, ov1;
  logic fd2, bk2, ov2;

  always #5 clk = ~clk;

  his_builder_pp_if #(.PIX_W(2), .BIN_W(4), .COUNT_W(8)) pk1 ();
  his_builder_pp_if #(.PIX_W(2), .BIN_W(4), .COUNT_W(2)) pk2 ();

  assign pk1.pk_ready = ready;
  assign pk2.pk_ready = ready;

  his_builder_pp #(.COUNT_W(8)) u_dut (
    .clk(clk), .res(res),
    .in_valid(in_valid), .in_bin(in_bin),
    .pk(pk1),
    .frame_done(fd1), .bank(bk1), .overrun(ov1)
  );

  his_builder_pp #(.COUNT_W(2)) u_dut2 (
    .clk(clk), .res(res),
    .in_valid(in_valid), .in_bin(in_bin),
    .pk(pk2),
    .frame_done(fd2), .bank(bk2), .overrun(ov2)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit run = 0;
  bit rmode = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int pix; int b1; int c1; int b2; int c2;
  } rec_t;

  rec_t q[$];
  int hp[$];
  int hb[$];
  int hcnt;
  bit pend_e, fd_e, bank_e, ovr_e, m_busy;

  function automatic int peak_of(int pix, int cw, bit want_bin);
    int c[16];
    int mx = 0;
    int mb = 0;
    int lim = (1 << cw) - 1;
    foreach (c[i]) c[i] = 0;
    for (int k = 0; k < hp.size(); k++) begin
      if (hp[k] == pix) begin
        int b;
        int n;
        b = hb[k];
`ifdef HIS_SAT_EN
        n = (c[b] == lim) ? c[b] : c[b] + 1;
`else
        n = (c[b] + 1) & lim;
`endif
        c[b] = n;
        if (n > mx) begin
          mx = n;
          mb = b;
        end
      end
    end
    return want_bin ? mb : mx;
  endfunction

  always @(posedge clk) begin
    if (res) begin
      q.delete();
      hp.delete();
      hb.delete();
      hcnt = 0;
      pend_e = 0; fd_e = 0; bank_e = 0; ovr_e = 0;
    end else begin
      m_busy = (q.size() != 0);
      if (m_busy && !pend_e && ready)
        void'(q.pop_front());
      pend_e = 0;
      fd_e = 0;
      if (in_valid) begin
        hp.push_back((hcnt / S) % N);
        hb.push_back(int'(in_bin));
        hcnt++;
        if (hcnt == FH) begin
          fd_e = 1;
          bank_e = ~bank_e;
          if (!m_busy) begin
            for (int p = 0; p < N; p++) begin
              rec_t r;
              r.pix = p;
              r.b1 = peak_of(p, 8, 1);
              r.c1 = peak_of(p, 8, 0);
              r.b2 = peak_of(p, 2, 1);
              r.c2 = peak_of(p, 2, 0);
              q.push_back(r);
            end
            pend_e = 1;
          end else begin
            ovr_e = 1;
          end
          hp.delete();
          hb.delete();
          hcnt = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run) begin
      bit v;
      v = (q.size() != 0) && !pend_e;
      chk("frame_done", fd1, fd_e);
      chk("bank", bk1, bank_e);
      chk("overrun", ov1, ovr_e);
      chk("pk_valid", pk1.pk_valid, v);
      chk("frame_done2", fd2, fd_e);
      chk("bank2", bk2, bank_e);
      chk("overrun2", ov2, ovr_e);
      chk("pk_valid2", pk2.pk_valid, v);
      if (v) begin
        chk("pk_pixel", pk1.pk_pixel, q[0].pix);
        chk("pk_bin", pk1.pk_bin, q[0].b1);
        chk("pk_count", pk1.pk_count, q[0].c1);
        chk("pk_pixel2", pk2.pk_pixel, q[0].pix);
        chk("pk_bin2", pk2.pk_bin, q[0].b2);
        chk("pk_count2", pk2.pk_count, q[0].c2);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input int b);
    in_valid = 1'b1;
    in_bin = 4'(b);
    if (rmode) ready = 1'($urandom_range(0, 1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      if (rmode) ready = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic wait_valid(input int lim);
    int k = 0;
    while (pk1.pk_valid !== 1'b1 && k < lim) begin
      step();
      k++;
    end
    chk("pk_valid_wait", pk1.pk_valid, 1);
  endtask

  task automatic rand_frame(input bit gaps);
    int h = 0;
    while (h < FH) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        hit($urandom_range(0, 3) == 0 ? 9 : $urandom_range(0, 15));
        h++;
      end
    end
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_fd"}, fd1, 0);
    chk({tag, "_bank"}, bk1, 0);
    chk({tag, "_ovr"}, ov1, 0);
    chk({tag, "_valid"}, pk1.pk_valid, 0);
    chk({tag, "_pixel"}, pk1.pk_pixel, 0);
    chk({tag, "_bin"}, pk1.pk_bin, 0);
    chk({tag, "_count"}, pk1.pk_count, 0);
    chk({tag, "_valid2"}, pk2.pk_valid, 0);
  endtask

  initial begin
    int tie[6] = '{3, 7, 7, 3, 3, 7};
    int t;
    res = 1'b1;
    in_valid = 1'b0;
    in_bin = '0;
    ready = 1'b1;
    repeat (2) step();
    chk_reset_outs("reset");
    res = 1'b0;
    run = 1;

    // Frame A: every hit on bin 5.
    for (int h = 0; h < FH; h++) hit(5);
    chk("A_frame_done", fd1, 1);
    chk("A_bank", bk1, 1);
    chk("A_valid_early", pk1.pk_valid, 0);
    step();
    chk("A_valid", pk1.pk_valid, 1);
    chk("A_pixel0", pk1.pk_pixel, 0);
    chk("A_bin0", pk1.pk_bin, 5);
    chk("A_count0", pk1.pk_count, 6);
    chk("A_bin0_cw2", pk2.pk_bin, 5);
    chk("A_count0_cw2", pk2.pk_count, 3);
    for (int p = 1; p < N; p++) begin
      step();
      chk("A_stream_pixel", pk1.pk_pixel, p);
      chk("A_stream_count", pk1.pk_count, 6);
    end
    step();
    chk("A_done_valid", pk1.pk_valid, 0);

    // Frame B: tie on pixel 0, record held under backpressure.
    ready = 1'b0;
    t = 0;
    for (int h = 0; h < FH; h++) begin
      if ((h / S) % N == 0) begin
        hit(tie[t]);
        t++;
      end else begin
        hit($urandom_range(0, 15));
      end
    end
    wait_valid(5);
    for (int k = 0; k < 10; k++) begin
      chk("B_hold_valid", pk1.pk_valid, 1);
      chk("B_hold_pixel", pk1.pk_pixel, 0);
      chk("B_tie_bin", pk1.pk_bin, 3);
      chk("B_tie_count", pk1.pk_count, 3);
      chk("B_tie_bin_cw2", pk2.pk_bin, 3);
      step();
    end
    ready = 1'b1;
    for (int p = 1; p < N; p++) begin
      step();
      chk("B_stream_pixel", pk1.pk_pixel, p);
      chk("B_stream_valid", pk1.pk_valid, 1);
    end
    idle(2);

    // Frames C/D: D ends while C is still stalled -> overrun.
    ready = 1'b0;
    rand_frame(0);
    rand_frame(0);
    chk("D_overrun", ov1, 1);
    ready = 1'b1;
    idle(8);

    // Frame E: reuses a bank that held an earlier frame.
    rmode = 1;
    rand_frame(1);
    idle(12);

    // Reset in the middle of an acquisition.
    rmode = 0;
    ready = 1'b1;
    for (int h = 0; h < 10; h++) hit($urandom_range(0, 15));
    res = 1'b1;
    step();
    chk_reset_outs("midres");
    res = 1'b0;
    rmode = 1;
    rand_frame(0);
    idle(12);

    for (int f = 0; f < 6; f++) begin
      rand_frame(1);
      if (f % 2 == 1) idle(10);
    end
    rmode = 0;
    ready = 1'b1;
    idle(20);
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
